// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: two-entry (main + skid) capture, immediate select, MEM/WB forwarding.
// Optional build macro ALU_OPERAND_FWD_EN enables forwarding and held-entry WB refresh.
module alu_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  id_operation,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_reg_write,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                      mem_reg_write,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                      ex_reg_write
);

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      alu_src;
    logic [OPCODE_LENGTH-1:0]  operation;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
  } entry_t;

  entry_t main_q, skid_q, main_d, skid_d;
  entry_t in_e, in_r, main_r, skid_r;
  logic   consume, accept;

  // A WB write landing on a held source keeps the stored copy current once the producer retires.
  function automatic entry_t refresh(input entry_t e, input logic we,
                                     input logic [REG_ADDR_WIDTH-1:0] wa,
                                     input logic [DATA_WIDTH-1:0] wd);
    entry_t r;
    r = e;
    if (FwdEn && we && (wa != '0)) begin
      if (e.rs1_addr == wa) r.rs1_data = wd;
      if (e.rs2_addr == wa) r.rs2_data = wd;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fwd(input logic [REG_ADDR_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] stored,
                                                input logic mwe,
                                                input logic [REG_ADDR_WIDTH-1:0] ma,
                                                input logic [DATA_WIDTH-1:0] md,
                                                input logic wwe,
                                                input logic [REG_ADDR_WIDTH-1:0] wa,
                                                input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] r;
    r = stored;
    if (FwdEn && (a != '0)) begin
      if (mwe && (ma == a))      r = md;
      else if (wwe && (wa == a)) r = wd;
    end
    return r;
  endfunction

  always_comb begin
    in_e           = '0;
    in_e.valid     = 1'b1;
    in_e.rs1_data  = id_rs1_data;
    in_e.rs2_data  = id_rs2_data;
    in_e.imm       = id_imm;
    in_e.alu_src   = id_alu_src;
    in_e.operation = id_operation;
    in_e.rs1_addr  = id_rs1_addr;
    in_e.rs2_addr  = id_rs2_addr;
    in_e.rd_addr   = id_rd_addr;
    in_e.reg_write = id_reg_write;

    in_r   = refresh(in_e, wb_reg_write, wb_rd_addr, wb_result);
    main_r = refresh(main_q, wb_reg_write, wb_rd_addr, wb_result);
    skid_r = refresh(skid_q, wb_reg_write, wb_rd_addr, wb_result);

    consume = main_q.valid && out_ready;
    accept  = in_valid && !skid_q.valid;

    main_d = main_r;
    skid_d = skid_r;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (consume || !main_q.valid) begin
      if (skid_q.valid) begin
        main_d       = skid_r;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        main_d = in_r;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = in_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  logic [DATA_WIDTH-1:0] rs2_fwd;

  assign in_ready     = !skid_q.valid;
  assign out_valid    = main_q.valid;
  assign SrcA         = fwd(main_q.rs1_addr, main_q.rs1_data, mem_reg_write, mem_rd_addr,
                            mem_result, wb_reg_write, wb_rd_addr, wb_result);
  assign rs2_fwd      = fwd(main_q.rs2_addr, main_q.rs2_data, mem_reg_write, mem_rd_addr,
                            mem_result, wb_reg_write, wb_rd_addr, wb_result);
  assign SrcB         = main_q.alu_src ? main_q.imm : rs2_fwd;
  assign Operation    = main_q.operation;
  assign ex_rd_addr   = main_q.rd_addr;
  assign ex_reg_write = main_q.reg_write && (main_q.rd_addr != '0);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table, directed multi-cycle sequences, random run vs queue model.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        src;
    logic [3:0]  op;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic        we;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic        mwe;
    logic [4:0]  ma;
    logic [31:0] mr;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wr;
    logic [31:0] ea_f, eb_f, ea_n, eb_n;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  instr_t      din = '0;
  logic [4:0]  mem_rd_addr = '0, wb_rd_addr = '0;
  logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
  logic [31:0] mem_result = '0, wb_result = '0;
  logic        in_ready, out_valid, ex_reg_write;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int failures = 0;
  instr_t q[$];

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .id_rs1_data(din.a), .id_rs2_data(din.b), .id_imm(din.imm), .id_alu_src(din.src),
    .id_operation(din.op), .id_rs1_addr(din.r1), .id_rs2_addr(din.r2), .id_rd_addr(din.rd),
    .id_reg_write(din.we), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic instr_t mki(input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic src, input logic [3:0] op);
    instr_t i;
    i.a = a; i.b = b; i.imm = imm; i.src = src; i.op = op;
    i.r1 = r1; i.r2 = r2; i.rd = 5'd1; i.we = 1'b1;
    return i;
  endfunction

  function automatic vec_t mk(input instr_t ins, input logic mwe, input logic [4:0] ma,
                              input logic [31:0] mr, input logic wwe, input logic [4:0] wa,
                              input logic [31:0] wr, input logic [31:0] eaf, input logic [31:0] ebf,
                              input logic [31:0] ean, input logic [31:0] ebn);
    vec_t v;
    v.ins = ins; v.mwe = mwe; v.ma = ma; v.mr = mr; v.wwe = wwe; v.wa = wa; v.wr = wr;
    v.ea_f = eaf; v.eb_f = ebf; v.ea_n = ean; v.eb_n = ebn;
    return v;
  endfunction

  // Reference: value a source would see given MEM/WB producers this cycle
  function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] stored);
    if (FWD && a != 0 && mem_reg_write && mem_rd_addr == a) return mem_result;
    if (FWD && a != 0 && wb_reg_write && wb_rd_addr == a) return wb_result;
    return stored;
  endfunction

  function automatic instr_t ref_refresh(input instr_t i);
    instr_t r = i;
    if (FWD && wb_reg_write && wb_rd_addr != 0) begin
      if (i.r1 == wb_rd_addr) r.a = wb_result;
      if (i.r2 == wb_rd_addr) r.b = wb_result;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_fwd;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    mem_rd_addr = '0; wb_rd_addr = '0; mem_result = '0; wb_result = '0;
  endtask

  task automatic drain;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; idle_fwd();
    tick(); tick(); tick();
    out_ready = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(mki(1, 2, 32'd5, 32'd7, 32'd0, 0, 4'h2), 0, 0, 0, 0, 0, 0, 32'd5, 32'd7, 32'd5, 32'd7);
    vecs[1] = mk(mki(1, 2, 32'd5, 32'd7, 32'hFFFF_FFFC, 1, 4'h3), 0, 0, 0, 0, 0, 0,
                 32'd5, 32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFFC);
    vecs[2] = mk(mki(3, 2, 32'h11, 32'h22, 0, 0, 4'h1), 1, 3, 32'hAA, 1, 3, 32'hBB,
                 32'hAA, 32'h22, 32'h11, 32'h22);
    vecs[3] = mk(mki(3, 2, 32'h11, 32'h22, 0, 0, 4'h1), 0, 3, 32'hAA, 1, 3, 32'hBB,
                 32'hBB, 32'h22, 32'h11, 32'h22);
    vecs[4] = mk(mki(0, 0, 32'h11, 32'h22, 0, 0, 4'h4), 1, 0, 32'hAA, 1, 0, 32'hBB,
                 32'h11, 32'h22, 32'h11, 32'h22);
    vecs[5] = mk(mki(1, 6, 32'd5, 32'h33, 0, 0, 4'h5), 1, 6, 32'h66, 0, 0, 0,
                 32'd5, 32'h66, 32'd5, 32'h33);
    vecs[6] = mk(mki(1, 6, 32'd5, 32'h33, 32'h44, 1, 4'h6), 1, 6, 32'h66, 1, 1, 32'h77,
                 32'h77, 32'h44, 32'd5, 32'h44);
    vecs[7] = mk(mki(3, 4, 32'h11, 32'h22, 0, 0, 4'h7), 0, 3, 32'hAA, 1, 5, 32'hBB,
                 32'h11, 32'h22, 32'h11, 32'h22);
    vecs[8] = mk(mki(2, 2, 32'd9, 32'd9, 0, 0, 4'h8), 1, 2, 32'hAA, 1, 1, 32'hBB,
                 32'hAA, 32'hAA, 32'd9, 32'd9);

    // Reset state
    #3;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    #9 rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_srca", SrcA, 0);
    check("rst_srcb", SrcB, 0);
    check("rst_op", {28'b0, Operation}, 0);
    check("rst_rd", {27'b0, ex_rd_addr}, 0);
    check("rst_we", {31'b0, ex_reg_write}, 0);

    // Single op: one-cycle latency, then empty
    @(negedge clk);
    out_ready = 1'b1;
    din = mki(1, 2, 32'd5, 32'd7, 0, 0, 4'b0010);
    din.rd = 5'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    check("single_valid", {31'b0, out_valid}, 1);
    check("single_srca", SrcA, 5);
    check("single_srcb", SrcB, 7);
    check("single_op", {28'b0, Operation}, 4'b0010);
    check("single_we_rd0", {31'b0, ex_reg_write}, 0);
    tick(); #1;
    check("single_after", {31'b0, out_valid}, 0);
    out_ready = 1'b0;

    // Operand select / forwarding table
    for (int i = 0; i < 9; i++) begin
      din = vecs[i].ins; in_valid = 1'b1; idle_fwd();
      tick();
      in_valid = 1'b0;
      mem_reg_write = vecs[i].mwe; mem_rd_addr = vecs[i].ma; mem_result = vecs[i].mr;
      wb_reg_write = vecs[i].wwe; wb_rd_addr = vecs[i].wa; wb_result = vecs[i].wr;
      #1;
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 1);
      check($sformatf("vec%0d_srca", i), SrcA, FWD ? vecs[i].ea_f : vecs[i].ea_n);
      check($sformatf("vec%0d_srcb", i), SrcB, FWD ? vecs[i].eb_f : vecs[i].eb_n);
      check($sformatf("vec%0d_we", i), {31'b0, ex_reg_write}, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0; idle_fwd();
    end
    drain();

    // Backpressure: A, B accepted, C refused until skid drains
    din = mki(1, 2, 1, 1, 0, 0, 4'h1); in_valid = 1'b1;
    tick();
    din.op = 4'h2; #1;
    check("bp_ready_after_a", {31'b0, in_ready}, 1);
    tick();
    din.op = 4'h3; #1;
    check("bp_ready_after_b", {31'b0, in_ready}, 0);
    tick(); #1;
    check("bp_hold_a", {28'b0, Operation}, 1);
    check("bp_still_full", {31'b0, in_ready}, 0);
    out_ready = 1'b1; #1;
    check("bp_out_a", {28'b0, Operation}, 1);
    tick(); #1;
    check("bp_out_b", {28'b0, Operation}, 2);
    check("bp_out_b_valid", {31'b0, out_valid}, 1);
    tick();
    in_valid = 1'b0; #1;
    check("bp_out_c", {28'b0, Operation}, 3);
    check("bp_out_c_valid", {31'b0, out_valid}, 1);
    tick(); #1;
    check("bp_empty", {31'b0, out_valid}, 0);
    out_ready = 1'b0;

    // Stall refresh: WB pulse for x4 while held
    din = mki(4, 0, 32'd1, 32'd0, 0, 0, 4'h9); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'd9; #1;
    check("refresh_during", SrcA, FWD ? 32'd9 : 32'd1);
    tick();
    idle_fwd(); #1;
    check("refresh_after", SrcA, FWD ? 32'd9 : 32'd1);
    tick(); #1;
    check("refresh_later", SrcA, FWD ? 32'd9 : 32'd1);
    drain();

    // Flush with both entries full and a pending input
    din = mki(1, 1, 1, 1, 0, 0, 4'hA); in_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    check("flush_valid", {31'b0, out_valid}, 0);
    check("flush_ready", {31'b0, in_ready}, 1);
    out_ready = 1'b1;
    tick(); #1;
    check("flush_nothing", {31'b0, out_valid}, 0);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    din = mki(1, 1, 32'h55, 32'h55, 0, 0, 4'hB); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    check("arst_pre", {31'b0, out_valid}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 0);
    check("arst_srca", SrcA, 0);
    check("arst_ready", {31'b0, in_ready}, 1);
    #1 rst_n = 1'b1;
    q.delete();

    // Random run against the queue model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 29) == 0);
      din.a         = $urandom; din.b = $urandom; din.imm = $urandom;
      din.src       = $urandom_range(0, 1);
      din.op        = 4'($urandom_range(0, 15));
      din.r1        = 5'($urandom_range(0, 3));
      din.r2        = 5'($urandom_range(0, 3));
      din.rd        = 5'($urandom_range(0, 3));
      din.we        = $urandom_range(0, 1);
      mem_reg_write = $urandom_range(0, 1);
      mem_rd_addr   = 5'($urandom_range(0, 3));
      mem_result    = $urandom;
      wb_reg_write  = $urandom_range(0, 1);
      wb_rd_addr    = 5'($urandom_range(0, 3));
      wb_result     = $urandom;
      #1;
      check("rnd_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      check("rnd_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      if (q.size() > 0) begin
        check("rnd_srca", SrcA, ref_src(q[0].r1, q[0].a));
        check("rnd_srcb", SrcB, q[0].src ? q[0].imm : ref_src(q[0].r2, q[0].b));
        check("rnd_op", {28'b0, Operation}, {28'b0, q[0].op});
        check("rnd_rd", {27'b0, ex_rd_addr}, {27'b0, q[0].rd});
        check("rnd_we", {31'b0, ex_reg_write}, {31'b0, q[0].we && q[0].rd != 0});
      end
      @(posedge clk);
      if (flush) q.delete();
      else begin
        automatic bit acc = in_valid && (q.size() < 2);
        if (out_ready && q.size() > 0) void'(q.pop_front());
        foreach (q[k]) q[k] = ref_refresh(q[k]);
        if (acc) q.push_back(ref_refresh(din));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
